// File: rtl/image_window_buffer.sv
// Image buffer filled by a row-major pixel stream, then scanned autonomously to
// emit every K x K window (all taps in parallel) through a valid/ready handshake.
module image_window_buffer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int ADDR_W = 10,
    parameter int OFFSET = 6,
    parameter int PAD_EN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_valid,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    output logic                    mem_full,
    input  logic                    start,
    input  logic [1:0]              stride,
    output logic                    busy,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [ADDR_W-1:0]       win_row,
    output logic [ADDR_W-1:0]       win_col,
    output logic [K*K*DATA_W-1:0]   win_data,
    output logic                    done
);

    localparam int DEPTH   = IMG_W * IMG_H;
    localparam int HALF    = (PAD_EN != 0) ? K / 2 : 0;
    localparam int ROW_MAX = (PAD_EN != 0) ? IMG_H - 1 : IMG_H - K;
    localparam int COL_MAX = (PAD_EN != 0) ? IMG_W - 1 : IMG_W - K;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t                  state_r;
    logic [DATA_W-1:0]       mem_r [DEPTH];
    logic [ADDR_W:0]         wr_cnt_r;
    logic [1:0]              stride_r;
    logic                    s1_valid_r;
    logic [ADDR_W-1:0]       s1_row_r;
    logic [ADDR_W-1:0]       s1_col_r;
    logic                    out_last_r;

    logic                    we_s;
    logic                    col_wrap_s;
    logic                    s1_last_s;
    logic [ADDR_W-1:0]       next_row_s;
    logic [ADDR_W-1:0]       next_col_s;
    logic [K*K*DATA_W-1:0]   taps_s;
    int                      tap_r_s;
    int                      tap_c_s;
    logic [ADDR_W-1:0]       rd_addr_s;

    assign we_s = !rst && !clear && (state_r == ST_LOAD) && wr_valid;

    // Pixel store; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wr_cnt_r[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Next window position: step the column, wrap to the next row band when past the edge
    always_comb begin
        col_wrap_s = (int'(s1_col_r) + int'(stride_r)) > COL_MAX;
        s1_last_s  = col_wrap_s && ((int'(s1_row_r) + int'(stride_r)) > ROW_MAX);
        if (col_wrap_s) begin
            next_col_s = '0;
            next_row_s = s1_row_r + ADDR_W'(stride_r);
        end else begin
            next_col_s = s1_col_r + ADDR_W'(stride_r);
            next_row_s = s1_row_r;
        end
    end

    // Gather all taps of the addressed window; out-of-image taps read as exact zero
    always_comb begin
        taps_s    = '0;
        tap_r_s   = 0;
        tap_c_s   = 0;
        rd_addr_s = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                tap_r_s = int'(s1_row_r) + i - HALF;
                tap_c_s = int'(s1_col_r) + j - HALF;
                if (tap_r_s >= 0 && tap_r_s < IMG_H && tap_c_s >= 0 && tap_c_s < IMG_W) begin
                    rd_addr_s = ADDR_W'(tap_r_s * IMG_W + tap_c_s);
                    taps_s[(i*K+j)*DATA_W +: DATA_W] = mem_r[rd_addr_s] + DATA_W'(OFFSET);
                end else begin
                    taps_s[(i*K+j)*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    // Control FSM with the address stage (s1_*) feeding the registered window outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_LOAD;
            wr_cnt_r   <= '0;
            wr_ready   <= 1'b1;
            mem_full   <= 1'b0;
            busy       <= 1'b0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            win_data   <= '0;
            done       <= 1'b0;
            stride_r   <= 2'd1;
            s1_valid_r <= 1'b0;
            s1_row_r   <= '0;
            s1_col_r   <= '0;
            out_last_r <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state_r    <= ST_LOAD;
                wr_cnt_r   <= '0;
                wr_ready   <= 1'b1;
                mem_full   <= 1'b0;
                busy       <= 1'b0;
                win_valid  <= 1'b0;
                s1_valid_r <= 1'b0;
                out_last_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_LOAD: begin
                        if (wr_valid) begin
                            wr_cnt_r <= wr_cnt_r + (ADDR_W+1)'(1);
                            if (wr_cnt_r == (ADDR_W+1)'(DEPTH - 1)) begin
                                state_r  <= ST_FULL;
                                wr_ready <= 1'b0;
                                mem_full <= 1'b1;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (start) begin
                            stride_r   <= (stride == 2'd0) ? 2'd1 : stride;
                            s1_row_r   <= '0;
                            s1_col_r   <= '0;
                            s1_valid_r <= 1'b1;
                            out_last_r <= 1'b0;
                            busy       <= 1'b1;
                            state_r    <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (!win_valid || win_ready) begin
                            if (win_valid && out_last_r) begin
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                win_valid  <= 1'b0;
                                out_last_r <= 1'b0;
                                state_r    <= ST_FULL;
                            end else begin
                                win_valid <= s1_valid_r;
                                if (s1_valid_r) begin
                                    win_row    <= s1_row_r;
                                    win_col    <= s1_col_r;
                                    win_data   <= taps_s;
                                    out_last_r <= s1_last_s;
                                    if (s1_last_s) begin
                                        s1_valid_r <= 1'b0;
                                    end else begin
                                        s1_row_r <= next_row_s;
                                        s1_col_r <= next_col_s;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_window_buffer.sv
// Bench: one valid-only and one zero-padded buffer share a stimulus stream and are
// compared every cycle against an image-array model of the window sequence.
module tb_image_window_buffer;

    localparam int DW   = 16;
    localparam int IW   = 28;
    localparam int IH   = 28;
    localparam int KK   = 3;
    localparam int AW   = 10;
    localparam int OFS  = 6;
    localparam int NPIX = IW * IH;
    localparam int WD   = KK * KK * DW;

    logic          clk = 1'b0;
    logic          rst, clear, wr_valid, start, win_ready;
    logic [DW-1:0] wr_data;
    logic [1:0]    stride;

    logic          wr_ready_v [2];
    logic          mem_full_v [2];
    logic          busy_v     [2];
    logic          win_valid_v[2];
    logic          done_v     [2];
    logic [AW-1:0] win_row_v  [2];
    logic [AW-1:0] win_col_v  [2];
    logic [WD-1:0] win_data_v [2];

    int errors = 0;
    int checks = 0;

    int            img[NPIX];
    int            exp_row[2][1024];
    int            exp_col[2][1024];
    int            exp_n[2], exp_idx[2], xfer_cnt[2], done_cnt[2];
    bit            scan_active[2];
    logic [WD-1:0] first_data[2], last_data[2];
    int            last_row[2], last_col[2];
    bit            hold_prev[2];
    logic [AW-1:0] prev_row[2], prev_col[2];
    logic [WD-1:0] prev_data[2];
    bit            clr_prev;
    int            cr, cc;

    always #5 clk = ~clk;

    image_window_buffer #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .ADDR_W(AW),
                          .OFFSET(OFS), .PAD_EN(0)) u_dut_valid (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready_v[0]), .mem_full(mem_full_v[0]), .start(start), .stride(stride),
        .busy(busy_v[0]), .win_valid(win_valid_v[0]), .win_ready(win_ready),
        .win_row(win_row_v[0]), .win_col(win_col_v[0]), .win_data(win_data_v[0]),
        .done(done_v[0])
    );

    image_window_buffer #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .ADDR_W(AW),
                          .OFFSET(OFS), .PAD_EN(1)) u_dut_pad (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready_v[1]), .mem_full(mem_full_v[1]), .start(start), .stride(stride),
        .busy(busy_v[1]), .win_valid(win_valid_v[1]), .win_ready(win_ready),
        .win_row(win_row_v[1]), .win_col(win_col_v[1]), .win_data(win_data_v[1]),
        .done(done_v[1])
    );

    task automatic chk(input bit ok, input string name, input logic [WD-1:0] act,
                       input logic [WD-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Window contents straight from the image: pixel + offset, zero outside the image
    function automatic logic [WD-1:0] model_win(input int pad, input int r, input int c);
        logic [WD-1:0] w;
        int h, tr, tc;
        w = '0;
        h = (pad != 0) ? KK / 2 : 0;
        for (int i = 0; i < KK; i++) begin
            for (int j = 0; j < KK; j++) begin
                tr = r + i - h;
                tc = c + j - h;
                if (tr >= 0 && tr < IH && tc >= 0 && tc < IW)
                    w[(i*KK+j)*DW +: DW] = DW'(img[tr*IW+tc] + OFS);
            end
        end
        return w;
    endfunction

    task automatic build_expected(input int d, input int s);
        int se, rmax, cmax;
        se   = (s == 0) ? 1 : s;
        rmax = (d != 0) ? IH - 1 : IH - KK;
        cmax = (d != 0) ? IW - 1 : IW - KK;
        exp_n[d] = 0;
        exp_idx[d] = 0;
        for (int r = 0; r <= rmax; r += se) begin
            for (int c = 0; c <= cmax; c += se) begin
                exp_row[d][exp_n[d]] = r;
                exp_col[d][exp_n[d]] = c;
                exp_n[d]++;
            end
        end
        scan_active[d] = 1'b1;
        done_cnt[d] = 0;
        xfer_cnt[d] = 0;
    endtask

    // Per-cycle compare of both DUTs against the expected window sequence
    always @(negedge clk) begin
        if (rst) begin
            hold_prev[0] = 1'b0;
            hold_prev[1] = 1'b0;
            clr_prev = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (clr_prev)
                    chk(!win_valid_v[d] && wr_ready_v[d] && !busy_v[d], "clear_drop",
                        {win_valid_v[d], wr_ready_v[d], busy_v[d]}, 3'b010);
                else if (hold_prev[d])
                    chk(win_valid_v[d] && win_row_v[d] == prev_row[d] &&
                        win_col_v[d] == prev_col[d] && win_data_v[d] == prev_data[d],
                        "hold_stable", win_data_v[d], prev_data[d]);
                if (win_valid_v[d] && win_ready) begin
                    if (exp_idx[d] >= exp_n[d]) begin
                        chk(1'b0, "extra_window", {win_row_v[d], win_col_v[d]}, '0);
                    end else begin
                        cr = exp_row[d][exp_idx[d]];
                        cc = exp_col[d][exp_idx[d]];
                        chk(win_row_v[d] == AW'(cr) && win_col_v[d] == AW'(cc), "position",
                            {win_row_v[d], win_col_v[d]}, {AW'(cr), AW'(cc)});
                        chk(win_data_v[d] == model_win(d, cr, cc), "taps",
                            win_data_v[d], model_win(d, cr, cc));
                        exp_idx[d]++;
                    end
                    if (xfer_cnt[d] == 0) first_data[d] = win_data_v[d];
                    last_data[d] = win_data_v[d];
                    last_row[d]  = int'(win_row_v[d]);
                    last_col[d]  = int'(win_col_v[d]);
                    xfer_cnt[d]++;
                end
                if (done_v[d]) begin
                    chk(scan_active[d] && exp_idx[d] == exp_n[d] && !busy_v[d] && !win_valid_v[d],
                        "done", exp_idx[d], exp_n[d]);
                    done_cnt[d]++;
                    scan_active[d] = 1'b0;
                end
                hold_prev[d] = win_valid_v[d] && !win_ready;
                prev_row[d]  = win_row_v[d];
                prev_col[d]  = win_col_v[d];
                prev_data[d] = win_data_v[d];
            end
            clr_prev = clear;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rmode 0: ready high with a 5-cycle stall; rmode 1: random ready. clear_at >= 0 aborts.
    task automatic do_scan(input logic [1:0] s, input int rmode, input int clear_at);
        build_expected(0, int'(s));
        build_expected(1, int'(s));
        win_ready = 1'b1;
        stride = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        stride = s + 2'd1;
        for (int d = 0; d < 2; d++)
            chk(busy_v[d] && !win_valid_v[d], "start_lat1", {busy_v[d], win_valid_v[d]}, 2'b10);
        tick();
        for (int d = 0; d < 2; d++)
            chk(win_valid_v[d], "start_lat2", win_valid_v[d], 1'b1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!scan_active[0] && !scan_active[1]) break;
            if (clear_at >= 0 && xfer_cnt[0] == clear_at) begin
                clear = 1'b1;
                scan_active[0] = 1'b0;
                scan_active[1] = 1'b0;
                tick();
                clear = 1'b0;
                break;
            end
            if (rmode == 1) win_ready = ($urandom_range(0, 3) != 0);
            else            win_ready = !(cyc >= 50 && cyc < 55);
            tick();
        end
        chk(!scan_active[0] && !scan_active[1], "scan_timeout", {scan_active[0], scan_active[1]}, 2'b00);
        repeat (4) tick();
        if (clear_at < 0) begin
            for (int d = 0; d < 2; d++)
                chk(done_cnt[d] == 1 && xfer_cnt[d] == exp_n[d], "done_once_count",
                    {done_cnt[d], xfer_cnt[d]}, {32'd1, exp_n[d]});
        end
        win_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [WD-1:0] lit;
        rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0;
        start = 1'b0; stride = 2'd1; win_ready = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++)
            chk(wr_ready_v[d] && !mem_full_v[d] && !busy_v[d] && !win_valid_v[d] && !done_v[d] &&
                win_row_v[d] == '0 && win_col_v[d] == '0 && win_data_v[d] == '0,
                "reset_values", win_data_v[d], '0);
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int d = 0; d < 2; d++)
            chk(!busy_v[d] && wr_ready_v[d], "start_in_load", busy_v[d], 1'b0);

        // 790 writes of pixel[a]=a; only the first 784 may land
        for (int a = 0; a < 790; a++) begin
            wr_valid = 1'b1;
            wr_data = DW'(a);
            if (a < NPIX) img[a] = a;
            tick();
            if (a == NPIX - 2 || a == NPIX - 1 || a == 789)
                for (int d = 0; d < 2; d++)
                    chk(mem_full_v[d] == (a >= NPIX - 1) && wr_ready_v[d] == (a < NPIX - 1),
                        "mem_full_edge", {mem_full_v[d], wr_ready_v[d]},
                        {a >= NPIX - 1, a < NPIX - 1});
        end
        wr_valid = 1'b0;

        do_scan(2'd1, 0, -1);
        lit = {16'd64, 16'd63, 16'd62, 16'd36, 16'd35, 16'd34, 16'd8, 16'd7, 16'd6};
        chk(first_data[0] == lit, "first_window_s1", first_data[0], lit);
        chk(xfer_cnt[0] == 676 && last_row[0] == 25 && last_col[0] == 25, "last_s1",
            {xfer_cnt[0], last_row[0], last_col[0]}, {32'd676, 32'd25, 32'd25});
        lit = {16'd35, 16'd34, 16'd0, 16'd7, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0};
        chk(first_data[1] == lit, "first_window_pad", first_data[1], lit);
        chk(xfer_cnt[1] == 784, "count_pad", xfer_cnt[1], 784);

        do_scan(2'd2, 1, -1);
        chk(xfer_cnt[0] == 169 && last_row[0] == 24 && last_col[0] == 24, "last_s2",
            {xfer_cnt[0], last_row[0], last_col[0]}, {32'd169, 32'd24, 32'd24});
        chk(last_data[0][15:0] == 16'd702, "last_tap_s2", last_data[0][15:0], 16'd702);
        chk(xfer_cnt[1] == 196, "count_pad_s2", xfer_cnt[1], 196);

        do_scan(2'd1, 0, 100);
        for (int d = 0; d < 2; d++)
            chk(done_cnt[d] == 0 && wr_ready_v[d] && !mem_full_v[d], "after_clear",
                {done_cnt[d], wr_ready_v[d], mem_full_v[d]}, {32'd0, 2'b10});

        // Clear colliding with a write must discard it, then reload random pixels
        clear = 1'b1; wr_valid = 1'b1; wr_data = 16'hDEAD;
        tick();
        clear = 1'b0;
        for (int a = 0; a < NPIX; a++) img[a] = int'($urandom_range(0, 65535));
        img[0] = 65533;
        n = 0;
        while (n < NPIX) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data = DW'(img[n]);
            tick();
            if (wr_valid) n++;
        end
        wr_valid = 1'b0;
        tick();
        for (int d = 0; d < 2; d++)
            chk(mem_full_v[d] && !wr_ready_v[d], "reload_full", {mem_full_v[d], wr_ready_v[d]}, 2'b10);

        do_scan(2'($urandom_range(0, 3)), 1, -1);
        do_scan(2'($urandom_range(1, 3)), 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_window_buffer.md
# image_window_buffer

Parametrised image buffer for the convolution layer. It is filled by a sequential pixel stream and then scans the stored image autonomously. For each K×K window position it emits all K² taps in parallel through a valid/ready handshake. Image size, kernel size, stride, input offset and zero-padding mode are configurable. It sits between the image loader on the processor bus and the MAC array / max-pooling stage.

## Interface
Parameters:
- DATA_W, 16, pixel width.
- IMG_W, 28, image columns.
- IMG_H, 28, image rows.
- K, 3, window size; odd, 1..5.
- ADDR_W, 10, internal address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.
- OFFSET, 6, signed constant added to every real (non-padded) tap.
- PAD_EN, 0, 0 = valid-only windows (origin at top-left tap); 1 = same-size output with window centred on the pixel and out-of-image taps forced to 0.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  drop stored image: write count ← 0, state ← LOAD; overrides everything except rst.
- wr_valid  in  1  pixel write request.
- wr_data  in  DATA_W  pixel, row-major order.
- wr_ready  out  1  high in LOAD.
- mem_full  out  1  high when IMG_W·IMG_H pixels are stored.
- start  in  1  begin scan; sampled only in FULL.
- stride  in  2  window step, 1..3; value 0 is treated as 1; latched on start.
- busy  out  1  high in SCAN.
- win_valid  out  1  window output valid.
- win_ready  in  1  consumer accepts the window.
- win_row, win_col  out  ADDR_W  window position (origin row/col when PAD_EN=0, centre row/col when PAD_EN=1).
- win_data  out  K·K·DATA_W  taps; tap (i,j) occupies bits [(i·K+j)·DATA_W +: DATA_W], where i is the row offset and j the column offset.
- done  out  1  one-cycle pulse after the last window is accepted.

## Operation
- FSM states: LOAD → FULL → SCAN → FULL.
- LOAD:
  - Each wr_valid writes wr_data at the internal write counter, then the counter increments.
  - When the counter reaches IMG_W·IMG_H, go to FULL.
- FULL:
  - mem_full=1 and wr_ready=0; writes are ignored.
  - On start: latch stride, set position to the first window, go to SCAN.
- SCAN:
  - Positions run row-major, column stepping by S, then row stepping by S.
  - PAD_EN=0 range: rows/cols 0..IMG_H-K / 0..IMG_W-K, giving ((IMG_H-K)/S+1)·((IMG_W-K)/S+1) windows.
  - PAD_EN=1 range: rows/cols 0..IMG_H-1 / 0..IMG_W-1, giving ceil(IMG_H/S)·ceil(IMG_W/S) windows.
  - After the last window handshake: done pulses, state returns to FULL. The image is retained, so a new start rescans it, possibly with a different stride.
- Tap arithmetic:
  - Real tap = stored pixel + OFFSET, truncated modulo 2^DATA_W.
  - Padded tap = 0 exactly; no offset is applied.
- clear in SCAN aborts the scan: win_valid drops next cycle and no done is issued.
- clear together with wr_valid: clear wins and the write is discarded.
- Reset does not initialise memory contents.

## Timing
- Reset values:
  - state = LOAD, wr_ready = 1.
  - mem_full, busy, win_valid, done = 0.
  - win_row, win_col, win_data = 0.
  - write counter = 0.
- Write: 1 pixel per cycle while wr_valid and wr_ready. mem_full rises the cycle after the last write is accepted.
- start → first win_valid: 2 cycles (address generation register, then memory read register).
- Handshake:
  - A window transfers on a cycle with win_valid && win_ready.
  - While win_valid=1 and win_ready=0, win_data, win_row and win_col hold stable.
  - With win_ready held high, throughput is 1 window/cycle.
- done: asserted the cycle after the final transfer. busy falls in the same cycle; win_valid is 0 then.
- start while not in FULL, or while asserted together with clear, is ignored.

## Test plan
- IMG 28×28, K=3, S=1, PAD_EN=0, pixel[a]=a:
  - First window taps are 6,7,8,34,35,36,62,63,64.
  - Exactly 676 windows, with the last at row/col 25,25.
  - done is a single pulse; first win_valid comes 2 cycles after start.
- Same image, S=2: 169 windows; last origin is (24,24) with tap(0,0)=24·28+24+6=702.
- PAD_EN=1, S=1: window (0,0) taps are 0,0,0,0,6,7,0,34,35; 784 windows total.
- Backpressure: hold win_ready low 5 cycles mid-scan. Required: win_data/row/col unchanged, no window skipped or duplicated.
- Overflow: drive 790 writes. Required: mem_full after the 784th, wr_ready low, pixel 0 still reads back as 0+OFFSET.
- Assert clear at window 100 of a scan. Required: win_valid=0 the next cycle, no done, wr_ready=1, and a reload plus rescan produces correct data.
